multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multi-cycle MIPS core. It sequences the shared datapath (PC, unified memory, IR, register file, ALU) through fetch, decode, execute, memory and writeback states for R-type, lw, sw, beq, addi and j. It stalls on a memory-ready handshake and halts permanently on an illegal opcode or a memory timeout. It sits beside the datapath in the multi-cycle top level, in the same place the combinational main decoder occupies in the single-cycle core.

## Interface
- TIMEOUT, 16: number of consecutive MemReady=0 cycles tolerated in a memory wait state. Legal range 1..255. 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces state RST immediately
- Op  in  6  opcode, IR[31:26]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCEn  out  1  PC load enable
- IRWrite  out  1  IR load enable
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write enable
- RegDst  out  1  write register select: 0=rt, 1=rd
- MemtoReg  out  1  writeback data select: 0=ALUOut, 1=MDR
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A reg
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUOp  out  2  to ALU decoder: 00=add, 01=sub, 10=funct
- PCSrc  out  2  PC next select: 00=ALUResult, 01=ALUOut, 10=jump target
- Halted  out  1  sticky error/halt indicator
- State  out  4  current state code, for debug

## Operation
- State codes: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, HALT=15. Codes 13 and 14 are unreachable and go to HALT.
- Outputs are combinational from State, plus MemReady/Zero where noted. Any signal not listed for a state is 0.
- RST: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCEn=MemReady. Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: ALUSrcB=11. Next state by Op:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other value → HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10. Op=100011 → MEMRD, otherwise → MEMWR.
- MEMRD: IorD=1, MemRead=1. Goes to MEMWB on MemReady.
- MEMWB: MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1. MemWrite is held until the MemReady cycle, then the FSM goes to FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, PCEn=Zero. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCEn=1. Next state FETCH.
- HALT: all outputs 0 except Halted=1. HALT is left only by reset.
- Timeout counter, 8-bit:
  - In FETCH, MEMRD and MEMWR it increments on each cycle with MemReady=0.
  - It clears on MemReady=1 and in every other state.
  - When the count equals TIMEOUT-1 and MemReady=0, the FSM goes to HALT instead of staying.
  - TIMEOUT=0 means the counter never triggers HALT.

## Timing
- Reset: while reset=0, State=0 and all outputs are 0 asynchronously. After release, the first rising edge enters FETCH.
- Cycles per instruction with MemReady tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle of MemReady=0 in a wait state adds exactly 1 cycle.
- Op is sampled in DECODE and MEMADR only. IR is stable then because IRWrite=0.
- MemReady=1 in the same cycle the timeout would expire: the access completes and no HALT occurs.
- Reset asserted mid-operation, including during MEMWR: MemWrite and RegWrite drop to 0 without waiting for a clock edge. The partial instruction is abandoned.
- Zero is only used in BRANCH. PCEn in that state follows Zero combinationally.

## Test plan
- Reset, then MemReady=1 and program [addi $1,$0,5; beq $1,$1,+1; addi $3,$0,2; addi $3,$0,1; j 5] → State trace starts 0,1,2,10,11,1. The first instruction takes 4 cycles. After beq, the PC skips to the fourth instruction, ending with $3=1. j loops at PC 0x14.
- lw with MemReady held low 3 cycles in MEMRD → MEMRD lasts 4 cycles. RegWrite=1 and MemtoReg=1 for exactly one cycle afterwards.
- sw with MemReady low 2 cycles → MemWrite=1 for exactly 3 consecutive cycles, IorD=1 throughout, then FETCH.
- Op=111111 in DECODE → HALT on the next edge, Halted=1 and all enables 0. Further clocks keep HALT. reset=0 returns State to 0.
- TIMEOUT=4 with MemReady stuck at 0 in FETCH → HALT on the 4th edge. With MemReady=1 arriving on the 4th cycle instead → DECODE, no halt.
- reset=0 pulsed mid-MEMWR, between clock edges → MemWrite falls immediately and State=0. After release, FETCH resumes.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller is the master: it consumes Op/Zero/MemReady and drives every enable and select.
interface multicycle_controller_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       PCEn;
    logic       IRWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       Halted;
    logic [3:0] State;

    modport master (
        input  Op, Zero, MemReady,
        output PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, Halted, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, Halted, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: fetch/decode/execute/memory/writeback sequencing,
// memory-ready stalls with a bounded wait, and a sticky halt on illegal opcodes or memory timeouts.
module multicycle_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // TIMEOUT of 0 disables the watchdog; otherwise the last tolerated count is TIMEOUT-1.
    localparam bit         TMO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic [7:0] tmo_cnt_r;
    logic [7:0] tmo_cnt_next_s;
    logic       wait_state_s;
    logic       tmo_hit_s;

    // Memory-wait watchdog: counts consecutive not-ready cycles in the three wait states.
    always_comb begin
        wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
        tmo_hit_s    = TMO_EN && !bus.MemReady && (tmo_cnt_r == TMO_LAST);
        if (wait_state_s && !bus.MemReady) begin
            tmo_cnt_next_s = tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_next_s = 8'd0;
        end
    end

    // State and watchdog registers; reset drops straight to RST without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_RST;
            tmo_cnt_r <= 8'd0;
        end else begin
            state_r   <= next_state_s;
            tmo_cnt_r <= tmo_cnt_next_s;
        end
    end

    // Next-state selection; unused codes and unknown opcodes all collapse into HALT.
    always_comb begin
        next_state_s = S_HALT;
        case (state_r)
            S_RST:    next_state_s = S_FETCH;
            S_FETCH: begin
                if (bus.MemReady) begin
                    next_state_s = S_DECODE;
                end else if (tmo_hit_s) begin
                    next_state_s = S_HALT;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.Op)
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_HALT;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (bus.MemReady) begin
                    next_state_s = S_MEMWB;
                end else if (tmo_hit_s) begin
                    next_state_s = S_HALT;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR: begin
                if (bus.MemReady) begin
                    next_state_s = S_FETCH;
                end else if (tmo_hit_s) begin
                    next_state_s = S_HALT;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC:   next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_ADDIWB: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            S_HALT:   next_state_s = S_HALT;
            default:  next_state_s = S_HALT;
        endcase
    end

    // Datapath controls decoded from the state; only FETCH and BRANCH look at live inputs.
    always_comb begin
        bus.PCEn     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.PCSrc    = 2'b00;
        bus.Halted   = 1'b0;
        case (state_r)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                bus.PCEn    = bus.MemReady;
            end
            S_DECODE: bus.ALUSrcB = 2'b11;
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b01;
                bus.PCSrc   = 2'b01;
                bus.PCEn    = bus.Zero;
            end
            S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_ADDIWB: bus.RegWrite = 1'b1;
            S_JUMP: begin
                bus.PCSrc = 2'b10;
                bus.PCEn  = 1'b1;
            end
            S_HALT:   bus.Halted = 1'b1;
            default:  bus.Halted = 1'b0;
        endcase
    end

    assign bus.State = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a small behavioural datapath runs a short program,
// and per-scenario tasks drive Op/Zero/MemReady directly to probe stalls, halts and resets.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic        mr;
    logic        z_drv;
    logic        prog_mode;
    logic [5:0]  op_drv;
    int          tests;
    int          fails;
    logic [15:0] ctl;

    multicycle_controller_if bus ();

    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCEn,IRWrite,IorD,MemRead,MemWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc,Halted}
    always_comb ctl = {bus.PCEn, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.RegWrite,
                       bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
                       bus.Halted};

    // Behavioural multi-cycle datapath, active only while prog_mode is set.
    logic [31:0] mem [16];
    logic [31:0] rf  [8];
    logic [31:0] pc, ir, a_q, b_q, aluout_q, mdr_q;
    logic [31:0] simm, srca, srcb, alu, maddr, pcnext, wd;
    logic [2:0]  wreg;

    always_comb begin
        simm = {{16{ir[15]}}, ir[15:0]};
        srca = bus.ALUSrcA ? a_q : pc;
        case (bus.ALUSrcB)
            2'b00:   srcb = b_q;
            2'b01:   srcb = 32'd4;
            2'b10:   srcb = simm;
            default: srcb = {simm[29:0], 2'b00};
        endcase
        case (bus.ALUOp)
            2'b01:   alu = srca - srcb;
            2'b10:   alu = (ir[5:0] == 6'h22) ? (srca - srcb) : (srca + srcb);
            default: alu = srca + srcb;
        endcase
        maddr = bus.IorD ? aluout_q : pc;
        case (bus.PCSrc)
            2'b01:   pcnext = aluout_q;
            2'b10:   pcnext = {pc[31:28], ir[25:0], 2'b00};
            default: pcnext = alu;
        endcase
        wreg = bus.RegDst ? ir[13:11] : ir[18:16];
        wd   = bus.MemtoReg ? mdr_q : aluout_q;
    end

    assign bus.Op       = prog_mode ? ir[31:26] : op_drv;
    assign bus.Zero     = prog_mode ? (alu == 32'd0) : z_drv;
    assign bus.MemReady = mr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'd0; ir <= 32'd0; a_q <= 32'd0; b_q <= 32'd0; aluout_q <= 32'd0; mdr_q <= 32'd0;
            for (int i = 0; i < 8; i++) rf[i] <= 32'd0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h20010005;   // addi $1,$0,5
            mem[1] <= 32'h10210001;   // beq  $1,$1,+1
            mem[2] <= 32'h20030002;   // addi $3,$0,2
            mem[3] <= 32'h20030001;   // addi $3,$0,1
            mem[4] <= 32'h08000005;   // j 5
            mem[5] <= 32'h08000005;   // j 5
        end else if (prog_mode) begin
            if (bus.IRWrite) ir <= mem[pc[5:2]];
            if (bus.PCEn) pc <= pcnext;
            a_q      <= rf[ir[23:21]];
            b_q      <= rf[ir[18:16]];
            aluout_q <= alu;
            mdr_q    <= mem[maddr[5:2]];
            if (bus.RegWrite && (wreg != 3'd0)) rf[wreg] <= wd;
            if (bus.MemWrite) mem[maddr[5:2]] <= b_q;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mr = 1'b1; #1;
        tests++; if (bus.State !== 4'd0) begin $display("FAIL reset_state: got %0d expected 0", bus.State); fails++; end
        tests++; if (ctl !== 16'h0000) begin $display("FAIL reset_outputs: got %h expected 0000", ctl); fails++; end
        step();
        tests++; if (bus.State !== 4'd0) begin $display("FAIL reset_held: got %0d expected 0", bus.State); fails++; end
        reset = 1'b1;
        step();
        tests++; if (bus.State !== 4'd1) begin $display("FAIL reset_release: got %0d expected 1", bus.State); fails++; end
    endtask

    task automatic test_program();
        logic [3:0] exp_tr [6];
        int n;
        exp_tr = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd11, 4'd1};
        prog_mode = 1'b1; mr = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            tests++;
            if (bus.State !== exp_tr[i]) begin
                $display("FAIL prog_trace[%0d]: got %0d expected %0d", i, bus.State, exp_tr[i]); fails++;
            end
        end
        for (int k = 0; k < 25; k++) step();
        n = 0;
        while (bus.State !== 4'd1 && n < 4) begin step(); n++; end
        tests++; if (bus.State !== 4'd1) begin $display("FAIL prog_loop_fetch: got %0d expected 1", bus.State); fails++; end
        tests++; if (pc !== 32'h14) begin $display("FAIL prog_jloop_pc: got %h expected 00000014", pc); fails++; end
        tests++; if (rf[1] !== 32'd5) begin $display("FAIL prog_r1: got %0d expected 5", rf[1]); fails++; end
        tests++; if (rf[3] !== 32'd1) begin $display("FAIL prog_r3: got %0d expected 1", rf[3]); fails++; end
        prog_mode = 1'b0;
    endtask

    task automatic test_rtype_addi_jump();
        mr = 1'b1; op_drv = 6'b000000;
        apply_reset(); step(); step();
        #1;
        tests++; if (ctl !== 16'h0060) begin $display("FAIL decode_ctl: got %h expected 0060", ctl); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd7 || ctl !== 16'h0090) begin $display("FAIL exec: got %0d/%h expected 7/0090", bus.State, ctl); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd8 || ctl !== 16'h0600) begin $display("FAIL aluwb: got %0d/%h expected 8/0600", bus.State, ctl); fails++; end
        op_drv = 6'b001000;
        step(); step(); step(); #1;
        tests++; if (bus.State !== 4'd10 || ctl !== 16'h00C0) begin $display("FAIL addiex: got %0d/%h expected 10/00c0", bus.State, ctl); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd11 || ctl !== 16'h0400) begin $display("FAIL addiwb: got %0d/%h expected 11/0400", bus.State, ctl); fails++; end
        op_drv = 6'b000010;
        step(); step(); step(); #1;
        tests++; if (bus.State !== 4'd12 || ctl !== 16'h8004) begin $display("FAIL jump: got %0d/%h expected 12/8004", bus.State, ctl); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd1 || ctl !== 16'hD020) begin $display("FAIL jump_to_fetch: got %0d/%h expected 1/d020", bus.State, ctl); fails++; end
    endtask

    task automatic test_branch();
        mr = 1'b1; op_drv = 6'b000100; z_drv = 1'b0;
        apply_reset(); step(); step(); step(); #1;
        tests++; if (bus.State !== 4'd9 || ctl !== 16'h008A) begin $display("FAIL branch_nz: got %0d/%h expected 9/008a", bus.State, ctl); fails++; end
        z_drv = 1'b1; #1;
        tests++; if (ctl !== 16'h808A) begin $display("FAIL branch_z: got %h expected 808a", ctl); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd1) begin $display("FAIL branch_next: got %0d expected 1", bus.State); fails++; end
    endtask

    task automatic test_lw_stall();
        int n, bad, wb;
        mr = 1'b1; op_drv = 6'b100011;
        apply_reset(); step(); step(); step(); #1;
        tests++; if (bus.State !== 4'd3 || ctl !== 16'h00C0) begin $display("FAIL memadr: got %0d/%h expected 3/00c0", bus.State, ctl); fails++; end
        step();
        n = 0; bad = 0;
        while (bus.State == 4'd4 && n < 10) begin
            mr = (n >= 3) ? 1'b1 : 1'b0; #1;
            if (ctl !== 16'h3000) bad++;
            n++; step();
        end
        tests++; if (n !== 4) begin $display("FAIL lw_memrd_len: got %0d expected 4", n); fails++; end
        tests++; if (bad !== 0) begin $display("FAIL lw_memrd_ctl: got %0d bad cycles expected 0", bad); fails++; end
        #1;
        tests++; if (bus.State !== 4'd5 || ctl !== 16'h0500) begin $display("FAIL memwb: got %0d/%h expected 5/0500", bus.State, ctl); fails++; end
        wb = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.RegWrite && bus.MemtoReg) wb++;
            step(); #1;
        end
        tests++; if (wb !== 1) begin $display("FAIL lw_wb_cycles: got %0d expected 1", wb); fails++; end
    endtask

    task automatic test_sw_stall();
        int n, wr;
        mr = 1'b1; op_drv = 6'b101011;
        apply_reset(); step(); step(); step(); step();
        n = 0; wr = 0;
        while (bus.State == 4'd6 && n < 10) begin
            mr = (n >= 2) ? 1'b1 : 1'b0; #1;
            if (ctl === 16'h2800) wr++;
            n++; step();
        end
        tests++; if (wr !== 3) begin $display("FAIL sw_memwrite_cycles: got %0d expected 3", wr); fails++; end
        tests++; if (bus.State !== 4'd1) begin $display("FAIL sw_next: got %0d expected 1", bus.State); fails++; end
    endtask

    task automatic test_illegal_op();
        mr = 1'b1; op_drv = 6'b111111;
        apply_reset(); step(); step(); step(); #1;
        tests++; if (bus.State !== 4'd15 || ctl !== 16'h0001) begin $display("FAIL illegal_halt: got %0d/%h expected 15/0001", bus.State, ctl); fails++; end
        mr = 1'b0; step(); mr = 1'b1; step(); step(); #1;
        tests++; if (bus.State !== 4'd15 || bus.Halted !== 1'b1) begin $display("FAIL halt_sticky: got %0d/%b expected 15/1", bus.State, bus.Halted); fails++; end
        reset = 1'b0; #1;
        tests++; if (bus.State !== 4'd0 || ctl !== 16'h0000) begin $display("FAIL halt_reset: got %0d/%h expected 0/0000", bus.State, ctl); fails++; end
        reset = 1'b1;
    endtask

    task automatic test_timeout();
        int bad;
        mr = 1'b0; op_drv = 6'b000000;
        apply_reset(); step();
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            #1; if (bus.State !== 4'd1 || ctl !== 16'h1020) bad++;
            if (k < 3) step();
        end
        tests++; if (bad !== 0) begin $display("FAIL tmo_wait: got %0d bad cycles expected 0", bad); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd15 || bus.Halted !== 1'b1) begin $display("FAIL tmo_halt: got %0d/%b expected 15/1", bus.State, bus.Halted); fails++; end
        apply_reset(); step(); step(); step(); step();
        mr = 1'b1; #1;
        tests++; if (bus.State !== 4'd1 || ctl !== 16'hD020) begin $display("FAIL tmo_last_ready: got %0d/%h expected 1/d020", bus.State, ctl); fails++; end
        step(); #1;
        tests++; if (bus.State !== 4'd2 || bus.Halted !== 1'b0) begin $display("FAIL tmo_rescued: got %0d/%b expected 2/0", bus.State, bus.Halted); fails++; end
    endtask

    task automatic test_async_reset_memwr();
        mr = 1'b1; op_drv = 6'b101011;
        apply_reset(); step(); step(); step(); step();
        mr = 1'b0; #1;
        tests++; if (bus.State !== 4'd6 || bus.MemWrite !== 1'b1) begin $display("FAIL memwr_entry: got %0d/%b expected 6/1", bus.State, bus.MemWrite); fails++; end
        #1; reset = 1'b0; #1;
        tests++; if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
            $display("FAIL async_reset: got %0d/%b/%b expected 0/0/0", bus.State, bus.MemWrite, bus.RegWrite); fails++;
        end
        @(negedge clk); reset = 1'b1; mr = 1'b1;
        step(); #1;
        tests++; if (bus.State !== 4'd1) begin $display("FAIL resume_fetch: got %0d expected 1", bus.State); fails++; end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; mr = 1'b0; z_drv = 1'b0; prog_mode = 1'b0; op_drv = 6'b000000;
        #7;
        test_reset();
        test_program();
        test_rtype_addi_jump();
        test_branch();
        test_lw_stall();
        test_sw_stall();
        test_illegal_op();
        test_timeout();
        test_async_reset_memwr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
